// File: rtl/status_sequencer.sv
// One-hot control-phase sequencer: fetch, operand fetch, transfer, execute, interrupt and multiply phases.
// Optional one-hot integrity checker (adds oh_err) enabled by defining SC_ONEHOT_CHK_EN.
module status_sequencer #(
  parameter int unsigned IT_LEN    = 3,
  parameter int unsigned MUL_W     = 4,
  parameter int unsigned MUL_STEPS = 8,
  parameter int unsigned ACK_TMO   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  ita,
  input  logic                  ack,
  input  logic                  from_d,
  input  logic                  to_d,
  input  logic                  op_mul,
  output logic [13+IT_LEN-1:0]  state_oh,
  output logic [MUL_W-1:0]      mul_idx,
  output logic                  mul_last,
  output logic                  bus_tmo
`ifdef SC_ONEHOT_CHK_EN
  ,
  output logic                  oh_err
`endif
);

  localparam int unsigned SW = 13 + IT_LEN;
  localparam int unsigned WW = 16;

  localparam int unsigned B_IF0 = 0;
  localparam int unsigned B_IF1 = 1;
  localparam int unsigned B_FF0 = 2;
  localparam int unsigned B_FF1 = 3;
  localparam int unsigned B_FF2 = 4;
  localparam int unsigned B_TF0 = 5;
  localparam int unsigned B_TF1 = 6;
  localparam int unsigned B_EX0 = 7;
  localparam int unsigned B_EX1 = 8;
  localparam int unsigned B_ML1 = 9;
  localparam int unsigned B_ML2 = 10;
  localparam int unsigned B_ML3 = 11;
  localparam int unsigned B_ML4 = 12;
  localparam int unsigned B_IT0 = 13;

  localparam logic [SW-1:0] ST_IF0 = SW'(1) << B_IF0;
  localparam logic [SW-1:0] ST_IF1 = SW'(1) << B_IF1;
  localparam logic [SW-1:0] ST_FF0 = SW'(1) << B_FF0;
  localparam logic [SW-1:0] ST_FF1 = SW'(1) << B_FF1;
  localparam logic [SW-1:0] ST_FF2 = SW'(1) << B_FF2;
  localparam logic [SW-1:0] ST_TF0 = SW'(1) << B_TF0;
  localparam logic [SW-1:0] ST_TF1 = SW'(1) << B_TF1;
  localparam logic [SW-1:0] ST_EX0 = SW'(1) << B_EX0;
  localparam logic [SW-1:0] ST_EX1 = SW'(1) << B_EX1;
  localparam logic [SW-1:0] ST_ML1 = SW'(1) << B_ML1;
  localparam logic [SW-1:0] ST_ML2 = SW'(1) << B_ML2;
  localparam logic [SW-1:0] ST_ML3 = SW'(1) << B_ML3;
  localparam logic [SW-1:0] ST_ML4 = SW'(1) << B_ML4;
  localparam logic [SW-1:0] ST_IT0 = SW'(1) << B_IT0;

  localparam logic [WW-1:0]    TMO_LAST  = WW'(ACK_TMO - 1);
  localparam logic [MUL_W-1:0] MUL_START = MUL_W'(MUL_STEPS - 1);

  logic [SW-1:0]    state_q, state_d;
  logic [MUL_W-1:0] mul_idx_q, mul_idx_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             tmo_q, tmo_d;
`ifdef SC_ONEHOT_CHK_EN
  logic             err_q, err_d;
`endif

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IF0;
      mul_idx_q <= '0;
      wait_q    <= '0;
      tmo_q     <= 1'b0;
`ifdef SC_ONEHOT_CHK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mul_idx_q <= mul_idx_d;
      wait_q    <= wait_d;
      tmo_q     <= tmo_d;
`ifdef SC_ONEHOT_CHK_EN
      err_q     <= err_d;
`endif
    end
  end

  // Next state: each active one-hot bit contributes its successor
  always_comb begin
    state_d   = state_q;
    mul_idx_d = mul_idx_q;
    wait_d    = wait_q;
    tmo_d     = 1'b0;
`ifdef SC_ONEHOT_CHK_EN
    err_d     = 1'b0;
`endif
    if (!stall) begin
      state_d = '0;
      if (state_q[B_IF0]) state_d |= ita ? ST_IT0 : ST_IF1;
      if (state_q[B_IF1]) state_d |= ST_FF0;
      if (state_q[B_FF0]) begin
        if (from_d) begin
          state_d |= ST_FF2;
        end else begin
          state_d |= ST_FF1;
          wait_d   = '0;
        end
      end
      if (state_q[B_FF1]) begin
        if (ack) begin
          state_d |= ST_FF2;
        end else if ((ACK_TMO != 0) && (wait_q == TMO_LAST)) begin
          state_d |= ST_IF0;
          tmo_d    = 1'b1;
        end else begin
          state_d |= ST_FF1;
          wait_d   = wait_q + WW'(1);
        end
      end
      if (state_q[B_FF2]) state_d |= ST_TF0;
      if (state_q[B_TF0]) state_d |= to_d ? ST_EX0 : ST_TF1;
      if (state_q[B_TF1]) state_d |= ST_EX0;
      // op_mul takes priority over the direct-to-D completion
      if (state_q[B_EX0]) state_d |= op_mul ? ST_ML1 : (to_d ? ST_IF0 : ST_EX1);
      if (state_q[B_EX1]) state_d |= ST_IF0;
      if (state_q[B_ML1]) begin
        state_d  |= ST_ML2;
        mul_idx_d = MUL_START;
      end
      if (state_q[B_ML2]) begin
        if (mul_idx_q == '0) begin
          state_d |= ST_ML3;
        end else begin
          state_d  |= ST_ML2;
          mul_idx_d = mul_idx_q - MUL_W'(1);
        end
      end
      if (state_q[B_ML3]) state_d |= ST_ML4;
      if (state_q[B_ML4]) state_d |= ST_IF0;
      for (int unsigned k = 0; k < IT_LEN; k++) begin
        if (state_q[B_IT0 + k]) begin
          if (k == IT_LEN - 1) state_d |= ST_IF0;
          else                 state_d |= SW'(1) << (B_IT0 + k + 1);
        end
      end
    end
`ifdef SC_ONEHOT_CHK_EN
    // Corrupted one-hot vector recovers to IF0 regardless of stall
    if ($countones(state_q) != 1) begin
      state_d   = ST_IF0;
      mul_idx_d = '0;
      wait_d    = '0;
      tmo_d     = 1'b0;
      err_d     = 1'b1;
    end
`endif
  end

  assign state_oh = state_q;
  assign mul_idx  = mul_idx_q;
  assign mul_last = state_q[B_ML2] && (mul_idx_q == '0);
  assign bus_tmo  = tmo_q;
`ifdef SC_ONEHOT_CHK_EN
  assign oh_err   = err_q;
`endif

endmodule

// File: tb/tb_status_sequencer.sv
// Randomized and directed bench for status_sequencer against a phase-number reference model.
module tb_status_sequencer;
  localparam int unsigned IT_LEN    = 5;
  localparam int unsigned MUL_W     = 4;
  localparam int unsigned MUL_STEPS = 8;
  localparam int unsigned ACK_TMO   = 4;
  localparam int unsigned SW        = 13 + IT_LEN;

  logic clk = 1'b0;
  logic reset, stall, ita, ack, from_d, to_d, op_mul;
  logic [SW-1:0]    state_oh;
  logic [MUL_W-1:0] mul_idx;
  logic             mul_last, bus_tmo;
`ifdef SC_ONEHOT_CHK_EN
  logic             oh_err;
`endif

  status_sequencer #(
    .IT_LEN(IT_LEN), .MUL_W(MUL_W), .MUL_STEPS(MUL_STEPS), .ACK_TMO(ACK_TMO)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .ita(ita), .ack(ack),
    .from_d(from_d), .to_d(to_d), .op_mul(op_mul),
    .state_oh(state_oh), .mul_idx(mul_idx), .mul_last(mul_last), .bus_tmo(bus_tmo)
`ifdef SC_ONEHOT_CHK_EN
    , .oh_err(oh_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase number (bit position), multiply index, ack wait count
  int          ph;
  int unsigned midx;
  int unsigned wcnt;
  bit          tmo;
  bit          err_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    ph = 0; midx = 0; wcnt = 0; tmo = 1'b0; err_exp = 1'b0;
  endtask

  task automatic model_step();
    err_exp = 1'b0;
    tmo     = 1'b0;
    if (stall) return;
    if (ph >= 13) begin
      ph = (ph == 13 + int'(IT_LEN) - 1) ? 0 : ph + 1;
      return;
    end
    case (ph)
      0:  ph = ita ? 13 : 1;
      1:  ph = 2;
      2:  if (from_d) ph = 4; else begin ph = 3; wcnt = 0; end
      3:  if (ack) ph = 4;
          else if (wcnt + 1 == ACK_TMO) begin ph = 0; tmo = 1'b1; end
          else wcnt++;
      4:  ph = 5;
      5:  ph = to_d ? 7 : 6;
      6:  ph = 7;
      7:  ph = op_mul ? 9 : (to_d ? 0 : 8);
      8:  ph = 0;
      9:  begin ph = 10; midx = MUL_STEPS - 1; end
      10: if (midx == 0) ph = 11; else midx--;
      11: ph = 12;
      default: ph = 0;
    endcase
  endtask

  task automatic check_all();
    check("state_oh", 32'(state_oh), 32'(1) << ph);
    check("mul_idx",  32'(mul_idx),  midx);
    check("mul_last", 32'(mul_last), 32'(ph == 10 && midx == 0));
    check("bus_tmo",  32'(bus_tmo),  32'(tmo));
`ifdef SC_ONEHOT_CHK_EN
    check("oh_err",   32'(oh_err),   32'(err_exp));
`endif
  endtask

  task automatic drive(input bit s, input bit i, input bit a, input bit f, input bit t, input bit m);
    stall = s; ita = i; ack = a; from_d = f; to_d = t; op_mul = m;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic tick_exp(input string tag, input logic [31:0] exp);
    tick();
    check(tag, 32'(state_oh), exp);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_state"},   32'(state_oh), 32'h1);
    check({tag, "_mul_idx"}, 32'(mul_idx),  32'h0);
    check({tag, "_bus_tmo"}, 32'(bus_tmo),  32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("reset_state", 32'(state_oh), 32'h1);
    check("reset_mul",   32'(mul_idx),  32'h0);
    check("reset_tmo",   32'(bus_tmo),  32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Short instruction: operand in D, result to D
    drive(0, 0, 0, 1, 1, 0);
    tick_exp("seq_if1", 32'h2);
    tick_exp("seq_ff0", 32'h4);
    tick_exp("seq_ff2", 32'h10);
    tick_exp("seq_tf0", 32'h20);
    tick_exp("seq_ex0", 32'h80);
    tick_exp("seq_if0", 32'h1);

    // Multiply: ML2 for exactly MUL_STEPS cycles
    drive(0, 0, 0, 1, 1, 1);
    tick_exp("mul_if1", 32'h2);
    tick_exp("mul_ff0", 32'h4);
    tick_exp("mul_ff2", 32'h10);
    tick_exp("mul_tf0", 32'h20);
    tick_exp("mul_ex0", 32'h80);
    tick_exp("mul_ml1", 32'h200);
    for (int i = 0; i < 8; i++) begin
      tick_exp("mul_ml2", 32'h400);
      check("mul_idx_dn", 32'(mul_idx), 32'(7 - i));
      check("mul_last_d", 32'(mul_last), 32'(i == 7));
    end
    tick_exp("mul_ml3", 32'h800);
    tick_exp("mul_ml4", 32'h1000);
    check("mul_idx_hold", 32'(mul_idx), 32'h0);
    tick_exp("mul_if0", 32'h1);

    // ACK timeout after four FF1 cycles
    drive(0, 0, 0, 0, 1, 0);
    tick_exp("tmo_if1", 32'h2);
    tick_exp("tmo_ff0", 32'h4);
    for (int i = 0; i < 4; i++) tick_exp("tmo_ff1", 32'h8);
    tick_exp("tmo_if0", 32'h1);
    check("tmo_pulse", 32'(bus_tmo), 32'h1);
    tick_exp("tmo_if1b", 32'h2);
    check("tmo_clear", 32'(bus_tmo), 32'h0);
    // ack on the fourth FF1 cycle beats the timeout
    tick_exp("ack_ff0", 32'h4);
    for (int i = 0; i < 4; i++) tick_exp("ack_ff1", 32'h8);
    drive(0, 0, 1, 0, 1, 0);
    tick_exp("ack_ff2", 32'h10);
    check("ack_no_tmo", 32'(bus_tmo), 32'h0);
    drive(0, 0, 0, 0, 1, 0);
    tick_exp("ack_tf0", 32'h20);
    tick_exp("ack_ex0", 32'h80);
    tick_exp("ack_if0", 32'h1);

    // Interrupt phases with a three-cycle stall in IT2
    drive(0, 1, 0, 0, 0, 0);
    tick_exp("it_it0", 32'h2000);
    drive(0, 0, 0, 0, 0, 0);
    tick_exp("it_it1", 32'h4000);
    tick_exp("it_it2", 32'h8000);
    drive(1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) tick_exp("it_stall", 32'h8000);
    drive(0, 0, 0, 0, 0, 0);
    tick_exp("it_it3", 32'h10000);
    tick_exp("it_it4", 32'h20000);
    tick_exp("it_if0", 32'h1);

    // Reset in the middle of ML2 at mul_idx = 5
    drive(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    check("pre_rst_idx", 32'(mul_idx), 32'h5);
    async_reset("mid_ml2_rst");
    check_all();

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset("rand_rst");
      end else begin
        drive($urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
              $urandom_range(0, 2) == 0);
        tick();
      end
    end

`ifdef SC_ONEHOT_CHK_EN
    // Corrupt the one-hot vector; the next edge must recover to IF0
    drive(1, 0, 0, 0, 0, 0);
    #1 force dut.state_q = SW'(32'h81);
    #1 release dut.state_q;
    @(posedge clk);
    #1;
    check("oh_recover", 32'(state_oh), 32'h1);
    check("oh_err_set", 32'(oh_err),   32'h1);
    check("oh_mul_clr", 32'(mul_idx),  32'h0);
    model_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("oh_err_clr", 32'(oh_err), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
